cache_fill_arbiter: RTL and testbench

- Shares the single pipelined main-memory read port between the instruction-cache miss path (IF stage) and the data-cache miss path (MEM stage).
- Serialises line fills: one fill at a time, D-side over I-side on conflict.
- Issues the word addresses of each line, steers returned words into the granted cache, and drives the stall signals that freeze the pipeline registers.

---
 rtl/cache_fill_arbiter_if.sv | 36 +++
 rtl/cache_fill_arbiter.sv | 117 +++++++++++
 tb/tb_cache_fill_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/cache_fill_arbiter_if.sv
// Signal bundle between the two cache miss paths, the shared main-memory read
// port and the cache fill port. The arbiter sits on the slave side.
interface cache_fill_arbiter_if #(
  parameter int WORDS = 8
) ();
  localparam int IDX_W = $clog2(WORDS);

  logic             i_miss;
  logic [15:0]      i_addr;
  logic             d_miss;
  logic [15:0]      d_addr;
  logic             mem_en;
  logic [15:0]      mem_addr;
  logic             mem_data_valid;
  logic [15:0]      mem_data;
  logic             fill_we;
  logic             fill_sel;
  logic [IDX_W-1:0] fill_idx;
  logic [15:0]      fill_data;
  logic             i_fill_done;
  logic             d_fill_done;
  logic             stall_if;
  logic             stall_mem;

  modport slave (
    input  i_miss, i_addr, d_miss, d_addr, mem_data_valid, mem_data,
    output mem_en, mem_addr, fill_we, fill_sel, fill_idx, fill_data,
           i_fill_done, d_fill_done, stall_if, stall_mem
  );

  modport master (
    output i_miss, i_addr, d_miss, d_addr, mem_data_valid, mem_data,
    input  mem_en, mem_addr, fill_we, fill_sel, fill_idx, fill_data,
           i_fill_done, d_fill_done, stall_if, stall_mem
  );
endinterface

// File: rtl/cache_fill_arbiter.sv
// Serialises I-cache and D-cache line fills over one pipelined memory read
// port (D wins ties), steers returned words into the granted cache and stalls.
module cache_fill_arbiter #(
  parameter int MEM_LAT = 4,
  parameter int WORDS   = 8
) (
  input  logic                clk,
  input  logic                rst,
  cache_fill_arbiter_if.slave bus
);
  localparam int          IDX_W     = $clog2(WORDS);
  localparam logic [15:0] LINE_MASK = ~16'(WORDS * 2 - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state_reg, state_next;
  logic             grant_reg, grant_next;   // 1 = D-cache
  logic [15:0]      base_reg, base_next;
  logic [IDX_W-1:0] issue_reg, issue_next;
  logic [4:0]       rcv_reg, rcv_next;
  logic [MEM_LAT-1:0] live_reg;
  logic             fill_we_reg, fill_sel_reg;
  logic [IDX_W-1:0] fill_idx_reg;
  logic [15:0]      fill_data_reg;
  logic             busy, accept, last_word;

  // live_reg tracks which returning slots belong to requests issued since the
  // last reset, so words still in flight across a reset never reach a cache.
  assign busy      = (state_reg != IDLE);
  assign accept    = bus.mem_data_valid && live_reg[MEM_LAT-1]
                     && ((state_reg == ISSUE) || (state_reg == DRAIN))
                     && (rcv_reg < 5'(WORDS));
  assign last_word = accept && (rcv_reg == 5'(WORDS - 1));

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    base_next  = base_reg;
    issue_next = issue_reg;
    rcv_next   = rcv_reg;
    if (accept) begin
      rcv_next = rcv_reg + 5'd1;
    end
    case (state_reg)
      IDLE: begin
        rcv_next   = '0;
        issue_next = '0;
        if (bus.d_miss) begin
          grant_next = 1'b1;
          base_next  = bus.d_addr & LINE_MASK;
          state_next = ISSUE;
        end else if (bus.i_miss) begin
          grant_next = 1'b0;
          base_next  = bus.i_addr & LINE_MASK;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        issue_next = issue_reg + IDX_W'(1);
        if (last_word) begin
          state_next = DONE;
        end else if (issue_reg == IDX_W'(WORDS - 1)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (last_word) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      grant_reg     <= 1'b0;
      base_reg      <= '0;
      issue_reg     <= '0;
      rcv_reg       <= '0;
      live_reg      <= '0;
      fill_we_reg   <= 1'b0;
      fill_sel_reg  <= 1'b0;
      fill_idx_reg  <= '0;
      fill_data_reg <= '0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      base_reg    <= base_next;
      issue_reg   <= issue_next;
      rcv_reg     <= rcv_next;
      live_reg    <= MEM_LAT'({live_reg, bus.mem_en});
      fill_we_reg <= accept;
      if (accept) begin
        fill_sel_reg  <= grant_reg;
        fill_idx_reg  <= rcv_reg[IDX_W-1:0];
        fill_data_reg <= bus.mem_data;
      end
    end
  end

  assign bus.mem_en      = (state_reg == ISSUE);
  assign bus.mem_addr    = bus.mem_en ? (base_reg + 16'({issue_reg, 1'b0})) : 16'h0000;
  assign bus.fill_we     = fill_we_reg;
  assign bus.fill_sel    = fill_sel_reg;
  assign bus.fill_idx    = fill_idx_reg;
  assign bus.fill_data   = fill_data_reg;
  assign bus.i_fill_done = (state_reg == DONE) && !grant_reg;
  assign bus.d_fill_done = (state_reg == DONE) && grant_reg;
  assign bus.stall_if    = bus.i_miss | (!grant_reg && busy);
  assign bus.stall_mem   = bus.d_miss | (grant_reg && busy);
endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter: a fixed-latency memory, a fill-schedule
// model checked every cycle, and literal expectations for each scenario.
module tb_cache_fill_arbiter;
  localparam int MEM_LAT  = 4;
  localparam int WORDS    = 8;
  localparam int DONE_OFF = WORDS + MEM_LAT + 1;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 0;
  bit   stray = 0;
  logic [15:0] data_tag = 16'h0000;

  cache_fill_arbiter_if #(.WORDS(WORDS)) bus ();

  cache_fill_arbiter #(.MEM_LAT(MEM_LAT), .WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return data_tag + 16'(a[3:1]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Memory: a request seen in cycle c answers in cycle c+MEM_LAT; not reset.
  logic        pend_v [MEM_LAT];
  logic [15:0] pend_a [MEM_LAT];
  initial for (int i = 0; i < MEM_LAT; i++) begin pend_v[i] = 1'b0; pend_a[i] = '0; end
  always @(negedge clk) begin
    logic        ret_v;
    logic [15:0] ret_a;
    ret_v = pend_v[MEM_LAT-1];
    ret_a = pend_a[MEM_LAT-1];
    for (int i = MEM_LAT - 1; i > 0; i--) begin
      pend_v[i] = pend_v[i-1];
      pend_a[i] = pend_a[i-1];
    end
    pend_v[0] = bus.mem_en;
    pend_a[0] = bus.mem_addr;
    bus.mem_data_valid = ret_v | stray;
    bus.mem_data       = ret_v ? mem_word(ret_a) : 16'hDEAD;
  end

  // Schedule model: a fill sampled at t0 issues on t0+1..t0+WORDS, writes word
  // k at t0+MEM_LAT+2+k and completes at t0+DONE_OFF.
  bit          m_act = 0;
  bit          m_g = 0;
  int          m_t0 = 0;
  logic [15:0] m_base = '0;
  always @(negedge clk) begin
    if (chk_en) begin
      int  off, idx_e;
      bit  en_e, we_e, done_e;
      off    = cyc - m_t0;
      en_e   = m_act && off >= 1 && off <= WORDS;
      we_e   = m_act && off >= MEM_LAT + 2 && off <= DONE_OFF;
      done_e = m_act && off == DONE_OFF;
      idx_e  = off - MEM_LAT - 2;
      chk("mem_en", 32'(bus.mem_en), 32'(en_e));
      chk("mem_addr", 32'(bus.mem_addr), en_e ? 32'(m_base + 16'(2 * (off - 1))) : 32'h0);
      chk("fill_we", 32'(bus.fill_we), 32'(we_e));
      if (we_e) begin
        chk("fill_sel", 32'(bus.fill_sel), 32'(m_g));
        chk("fill_idx", 32'(bus.fill_idx), 32'(idx_e));
        chk("fill_data", 32'(bus.fill_data), 32'(mem_word(m_base + 16'(2 * idx_e))));
      end
      chk("i_fill_done", 32'(bus.i_fill_done), 32'(done_e && !m_g));
      chk("d_fill_done", 32'(bus.d_fill_done), 32'(done_e && m_g));
      chk("stall_if", 32'(bus.stall_if), 32'(bus.i_miss | (m_act && !m_g)));
      chk("stall_mem", 32'(bus.stall_mem), 32'(bus.d_miss | (m_act && m_g)));
      if (done_e)
        $display("[TB] %s-line fill base=%h complete at cycle %0d", m_g ? "D" : "I", m_base, cyc);
      if (rst) begin
        m_act = 0;
      end else if (m_act) begin
        if (off == DONE_OFF) m_act = 0;
      end else if (bus.d_miss) begin
        m_act = 1; m_g = 1; m_t0 = cyc; m_base = bus.d_addr & 16'hFFF0;
      end else if (bus.i_miss) begin
        m_act = 1; m_g = 0; m_t0 = cyc; m_base = bus.i_addr & 16'hFFF0;
      end
    end
  end

  // Advance one cycle; the caches clear their miss when the done pulse shows.
  task automatic next_cycle();
    @(posedge clk); #1;
    if (bus.i_fill_done) bus.i_miss = 1'b0;
    if (bus.d_fill_done) bus.d_miss = 1'b0;
  endtask

  initial begin
    int nfills;
    rst = 1'b1;
    bus.i_miss = 1'b0; bus.i_addr = '0; bus.d_miss = 1'b0; bus.d_addr = '0;
    bus.mem_data_valid = 1'b0; bus.mem_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1;

    // Idle after reset, with stray valids that must be ignored.
    for (int k = 0; k < 10; k++) begin
      if (k > 0) next_cycle();
      stray = (k >= 3 && k <= 6);
      @(negedge clk);
      chk("idle outputs", 32'(|{bus.mem_en, bus.mem_addr, bus.fill_we, bus.fill_sel, bus.fill_idx,
          bus.fill_data, bus.i_fill_done, bus.d_fill_done, bus.stall_if, bus.stall_mem}), 32'h0);
    end
    stray = 0;
    repeat (2) next_cycle();

    // Single I miss.
    data_tag = 16'hA000;
    next_cycle();
    bus.i_miss = 1'b1; bus.i_addr = 16'h1236;
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) next_cycle();
      @(negedge clk);
      if (k >= 1 && k <= 8) chk("I mem_addr", 32'(bus.mem_addr), 32'h1230 + 32'(2 * (k - 1)));
      else chk("I mem_en off", 32'(bus.mem_en), 32'h0);
      if (k >= 6 && k <= 13) begin
        chk("I fill_idx", 32'(bus.fill_idx), 32'(k - 6));
        chk("I fill_data", 32'(bus.fill_data), 32'hA000 + 32'(k - 6));
      end
      chk("I i_fill_done", 32'(bus.i_fill_done), 32'(k == 13));
      chk("I stall_if", 32'(bus.stall_if), 32'(k <= 13));
    end
    repeat (2) next_cycle();

    // Simultaneous misses: D first, then I.
    data_tag = 16'h5100;
    next_cycle();
    bus.d_miss = 1'b1; bus.d_addr = 16'h4000;
    bus.i_miss = 1'b1; bus.i_addr = 16'h8000;
    for (int k = 0; k <= 28; k++) begin
      if (k > 0) next_cycle();
      @(negedge clk);
      chk("S d_fill_done", 32'(bus.d_fill_done), 32'(k == 13));
      chk("S i_fill_done", 32'(bus.i_fill_done), 32'(k == 27));
      chk("S stall_mem", 32'(bus.stall_mem), 32'(k <= 13));
      chk("S stall_if", 32'(bus.stall_if), 32'(k <= 27));
      if (k == 1)  chk("S D first addr", 32'(bus.mem_addr), 32'h4000);
      if (k == 14) chk("S gap mem_en", 32'(bus.mem_en), 32'h0);
      if (k == 15) chk("S I first addr", 32'(bus.mem_addr), 32'h8000);
    end
    repeat (2) next_cycle();

    // D miss dropped mid-fill.
    data_tag = 16'h7700;
    nfills = 0;
    next_cycle();
    bus.d_miss = 1'b1; bus.d_addr = 16'h4A52;
    for (int k = 0; k <= 15; k++) begin
      if (k > 0) next_cycle();
      if (k == 3) bus.d_miss = 1'b0;
      @(negedge clk);
      if (bus.fill_we) begin
        nfills++;
        chk("D fill_sel", 32'(bus.fill_sel), 32'h1);
      end
      if (k == 1) chk("D first addr", 32'(bus.mem_addr), 32'h4A50);
      chk("D d_fill_done", 32'(bus.d_fill_done), 32'(k == 13));
      chk("D stall_mem", 32'(bus.stall_mem), 32'(k <= 13));
      if (k == 15) chk("D no regrant", 32'(bus.mem_en), 32'h0);
    end
    chk("D fill count", 32'(nfills), 32'd8);
    repeat (2) next_cycle();

    // Reset in the middle of an I fill, then a fresh I miss.
    data_tag = 16'h3300;
    next_cycle();
    bus.i_miss = 1'b1; bus.i_addr = 16'h2000;
    for (int k = 0; k <= 21; k++) begin
      if (k > 0) next_cycle();
      if (k == 6) rst = 1'b1;
      if (k == 7) begin rst = 1'b0; bus.i_addr = 16'h3002; end
      @(negedge clk);
      if (k == 7) chk("R mem_en after rst", 32'(bus.mem_en), 32'h0);
      if (k >= 7 && k <= 12) chk("R stale fill_we", 32'(bus.fill_we), 32'h0);
      if (k == 8) chk("R new base", 32'(bus.mem_addr), 32'h3000);
      if (k == 13) chk("R first fill_we", 32'(bus.fill_we), 32'h1);
      chk("R i_fill_done", 32'(bus.i_fill_done), 32'(k == 20));
    end
    repeat (2) next_cycle();

    // Line at the top of the address space.
    data_tag = 16'h0C00;
    next_cycle();
    bus.d_miss = 1'b1; bus.d_addr = 16'hFFFF;
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) next_cycle();
      @(negedge clk);
      if (k >= 1 && k <= 8) chk("W mem_addr", 32'(bus.mem_addr), 32'(16'hFFF0 + 16'(2 * (k - 1))));
      else chk("W mem_en off", 32'(bus.mem_en), 32'h0);
      if (k >= 6 && k <= 13) chk("W fill_idx", 32'(bus.fill_idx), 32'(k - 6));
      chk("W d_fill_done", 32'(bus.d_fill_done), 32'(k == 13));
    end
    repeat (3) next_cycle();

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end
endmodule
